// File: rtl/spi_slave_receiver_if.sv
// spi_slave_receiver_if: SPI pins plus the local tx/rx word interface of the SPI target.
// The "slave" modport is the SPI target itself. The "master" modport is whoever drives
// the SPI pins and feeds tx words: the peer master together with the local client.
interface spi_slave_receiver_if #(
    parameter int DATA_LENGTH = 8
);
    logic                   SCK;
    logic                   SS_n;
    logic                   MOSI;
    logic                   MISO;
    logic [DATA_LENGTH-1:0] tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [DATA_LENGTH-1:0] rx_data;
    logic                   rx_valid;
    logic                   busy;

    modport master (
        output SCK, SS_n, MOSI, tx_data, tx_valid,
        input  MISO, tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  SCK, SS_n, MOSI, tx_data, tx_valid,
        output MISO, tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave_receiver.sv
// spi_slave_receiver: SPI target running entirely on sys_clk.
// SCK, SS_n and MOSI are oversampled; MOSI is deserialised LSB-first into rx_data, and a
// buffered tx word is serialised LSB-first onto MISO.
// Build macro SPI_SLAVE_MISO_TRISTATE_EN: when defined, MISO is released (1'bz) whenever the
// target is not in a frame, so several targets can share one MISO line. Otherwise MISO is 0.
module spi_slave_receiver #(
    parameter int DATA_LENGTH = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0
) (
    input  logic                sys_clk,
    input  logic                rst,
    spi_slave_receiver_if.slave bus
);
    localparam int                CNT_W    = (DATA_LENGTH > 2) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchronisers
    logic sck_meta_r, sck_sync_r, sck_prev_r;
    logic ss_meta_r, ss_sync_r, ss_prev_r;
    logic mosi_meta_r, mosi_sync_r;

    // SS_n arming after reset
    logic [1:0] settle_r;
    logic       ss_armed_r;

    // Edge events
    logic sck_rise_s, sck_fall_s;
    logic lead_edge_s, trail_edge_s;
    logic sample_edge_s, drive_edge_s;
    logic ss_fall_s, ss_rise_s;

    // FSM and control strobes
    state_t state_r, state_next_s;
    logic   sample_s, load_s, shift_s, abort_s;

    // Datapath
    logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_next_s;
    logic [DATA_LENGTH-2:0] rx_shift_r, rx_shift_next_s;
    logic [DATA_LENGTH-1:0] rx_word_s;
    logic                   word_done_s;
    logic [DATA_LENGTH-1:0] tx_shift_r, tx_shift_next_s;
    logic [DATA_LENGTH-1:0] tx_buf_r;
    logic                   tx_ready_r;
    logic [DATA_LENGTH-1:0] rx_data_r;
    logic                   rx_valid_r;
    logic                   busy_r;
    logic                   miso_r;

    // Bring SCK, SS_n and MOSI into sys_clk; SCK and SS_n keep a third flop for edge detection
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sck_meta_r  <= CPOL;
            sck_sync_r  <= CPOL;
            sck_prev_r  <= CPOL;
            ss_meta_r   <= 1'b1;
            ss_sync_r   <= 1'b1;
            ss_prev_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sck_meta_r  <= bus.SCK;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            ss_meta_r   <= bus.SS_n;
            ss_sync_r   <= ss_meta_r;
            ss_prev_r   <= ss_sync_r;
            mosi_meta_r <= bus.MOSI;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // The SS_n presets would fake a falling edge if the pin is low when reset ends, so an
    // SS_n fall only counts once real (post-reset) samples have shown SS_n high
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            settle_r   <= 2'd0;
            ss_armed_r <= 1'b0;
        end else begin
            if (settle_r != 2'd3) begin
                settle_r <= settle_r + 2'd1;
            end else begin
                settle_r <= settle_r;
            end
            if ((settle_r == 2'd3) && ss_prev_r) begin
                ss_armed_r <= 1'b1;
            end else begin
                ss_armed_r <= ss_armed_r;
            end
        end
    end

    // Decode SCK/SS_n edges into leading/trailing and sample/drive events for this mode
    always_comb begin
        sck_rise_s    = sck_sync_r & ~sck_prev_r;
        sck_fall_s    = ~sck_sync_r & sck_prev_r;
        lead_edge_s   = CPOL ? sck_fall_s : sck_rise_s;
        trail_edge_s  = CPOL ? sck_rise_s : sck_fall_s;
        sample_edge_s = CPHA ? trail_edge_s : lead_edge_s;
        drive_edge_s  = CPHA ? lead_edge_s : trail_edge_s;
        ss_fall_s     = ss_prev_r & ~ss_sync_r & ss_armed_r;
        ss_rise_s     = ~ss_prev_r & ss_sync_r;
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a frame opens on SS_n fall and closes on SS_n rise
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes; SCK edges outside a frame produce nothing
    always_comb begin
        sample_s = 1'b0;
        load_s   = 1'b0;
        shift_s  = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s && !CPHA) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    abort_s = 1'b1;
                end else begin
                    sample_s = sample_edge_s;
                    // bit_cnt==0 on a drive edge means a new word starts being driven
                    if (drive_edge_s && (bit_cnt_r == CNT_ZERO)) begin
                        load_s = 1'b1;
                    end else if (drive_edge_s) begin
                        shift_s = 1'b1;
                    end else begin
                        shift_s = 1'b0;
                    end
                end
            end
            default: abort_s = 1'b1;
        endcase
    end

    // Next values of the bit counter and both shift registers
    always_comb begin
        bit_cnt_next_s  = bit_cnt_r;
        rx_shift_next_s = rx_shift_r;
        word_done_s     = 1'b0;
        rx_word_s       = {mosi_sync_r, rx_shift_r};
        if (abort_s) begin
            bit_cnt_next_s  = CNT_ZERO;
            rx_shift_next_s = {(DATA_LENGTH-1){1'b0}};
        end else if (sample_s) begin
            rx_shift_next_s = rx_word_s[DATA_LENGTH-1:1];
            if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_next_s = CNT_ZERO;
                word_done_s    = 1'b1;
            end else begin
                bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
            end
        end else begin
            bit_cnt_next_s = bit_cnt_r;
        end

        // An empty buffer at load time sends all-zeros (silent underrun)
        if (load_s) begin
            tx_shift_next_s = tx_ready_r ? {DATA_LENGTH{1'b0}} : tx_buf_r;
        end else if (shift_s) begin
            tx_shift_next_s = tx_shift_r >> 1;
        end else begin
            tx_shift_next_s = tx_shift_r;
        end
    end

    // Shift registers, received word and the registered status/MISO outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bit_cnt_r  <= CNT_ZERO;
            rx_shift_r <= {(DATA_LENGTH-1){1'b0}};
            tx_shift_r <= {DATA_LENGTH{1'b0}};
            rx_data_r  <= {DATA_LENGTH{1'b0}};
            rx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            miso_r     <= 1'b0;
        end else begin
            bit_cnt_r  <= bit_cnt_next_s;
            rx_shift_r <= rx_shift_next_s;
            tx_shift_r <= tx_shift_next_s;
            rx_valid_r <= word_done_s;
            if (word_done_s) begin
                rx_data_r <= rx_word_s;
            end else begin
                rx_data_r <= rx_data_r;
            end
            busy_r <= (state_next_s == ST_ACTIVE) && (bit_cnt_next_s != CNT_ZERO);
            miso_r <= (state_next_s == ST_ACTIVE) ? tx_shift_next_s[0] : 1'b0;
        end
    end

    // One-word tx buffer: a load frees it; accepting while a load hits an empty buffer keeps the new word
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_buf_r   <= {DATA_LENGTH{1'b0}};
            tx_ready_r <= 1'b1;
        end else if (load_s && !tx_ready_r) begin
            tx_buf_r   <= tx_buf_r;
            tx_ready_r <= 1'b1;
        end else if (bus.tx_valid && tx_ready_r) begin
            tx_buf_r   <= bus.tx_data;
            tx_ready_r <= 1'b0;
        end else begin
            tx_buf_r   <= tx_buf_r;
            tx_ready_r <= tx_ready_r;
        end
    end

    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.tx_ready = tx_ready_r;
    assign bus.busy     = busy_r;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign bus.MISO = (state_r == ST_ACTIVE) ? miso_r : 1'bz;
`else
    assign bus.MISO = miso_r;
`endif

endmodule
